// File: rtl/ifmap_pkg.sv
// Shared types and helpers for the input-feature-map load controller.
package ifmap_pkg;

   // Controller states: idle, filling a word, holding a word for drain, tile done.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Number of bytes that make up one packed word whose MSB index is bus.
   function automatic int bytes_for_bus(input int bus);
      return (bus + 1) / 8;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Shift buffer that assembles a word from bytes: each new byte enters the
// top lane and everything already held moves down one lane, so the first
// byte of a word ends up in the lowest lane once the word is complete.
module byte_packer #(
   parameter int BUS = 31
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [7:0]   din,
   output logic [BUS:0] dout
);

   logic [BUS:0] data_q;

   // Shift a byte in at the top lane when enabled; clear discards a partial word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (clr) begin
         data_q <= '0;
      end else if (en) begin
         data_q <= {din, data_q[BUS:8]};
      end
   end

   assign dout = data_q;

endmodule

// File: rtl/ifmap_load_ctrl.sv
// Sequences the ifmap byte packer for one tile: accepts bytes, hands each
// completed word to the PE array, counts words and flags tile completion.
module ifmap_load_ctrl
   import ifmap_pkg::*;
#(
   parameter int BUS   = 31,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_words,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [BUS:0]     m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic             done
);

   localparam int BYTES = bytes_for_bus(BUS);
   localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

   state_t           state;
   logic [CNT_W-1:0] words_left;
   logic [BC_W-1:0]  byte_cnt;
   logic             accept;

   // Abort masks s_ready in the same cycle so a byte offered then is never taken.
   assign s_ready = (state == ST_FILL) && !abort;
   assign accept  = s_valid && s_ready;
   assign m_valid = (state == ST_HOLD);
   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_DONE);

   // Tile FSM with its byte and word counters; abort overrides every transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         words_left <= '0;
         byte_cnt   <= '0;
      end else if (abort) begin
         state      <= ST_IDLE;
         words_left <= '0;
         byte_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_words != '0) begin
                     state      <= ST_FILL;
                     words_left <= cfg_words;
                     byte_cnt   <= '0;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_FILL: begin
               if (accept) begin
                  if (byte_cnt == LAST_BYTE) begin
                     state    <= ST_HOLD;
                     byte_cnt <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + BC_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (m_ready) begin
                  words_left <= words_left - CNT_W'(1);
                  if (words_left == CNT_W'(1)) begin
                     state <= ST_DONE;
                  end else begin
                     state <= ST_FILL;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   byte_packer #(
      .BUS (BUS)
   ) u_packer (
      .clk  (clk),
      .rst  (rst),
      .clr  (abort),
      .en   (accept),
      .din  (s_data),
      .dout (m_data)
   );

endmodule

// File: tb/tb_ifmap_load_ctrl.sv
// Directed self-checking bench for ifmap_load_ctrl with BUS=31 (4-byte words).
module tb_ifmap_load_ctrl;

   localparam int BUS   = 31;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] cfg_words;
   logic [7:0]       s_data;
   logic             s_valid;
   logic             s_ready;
   logic [BUS:0]     m_data;
   logic             m_valid;
   logic             m_ready;
   logic             busy;
   logic             done;

   int tests     = 0;
   int fails     = 0;
   int done_seen = 0;

   ifmap_load_ctrl #(
      .BUS   (BUS),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .cfg_words (cfg_words),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .busy      (busy),
      .done      (done)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Count every cycle in which done is high, to catch missing or extra pulses.
   always @(posedge clk) begin
      if (done) done_seen++;
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start     = 1'b0;
      abort     = 1'b0;
      cfg_words = '0;
      s_data    = '0;
      s_valid   = 1'b0;
      m_ready   = 1'b0;
   endtask

   task automatic start_tile(input logic [CNT_W-1:0] n);
      cfg_words = n;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   // Offer one byte and wait (bounded) until the controller takes it.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited  = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (!s_ready && waited < 20) begin
         tick();
         waited++;
      end
      tests++;
      if (s_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL send_byte_timeout: s_ready=%b required 1 for byte %h", s_ready, b);
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_s_ready: got %b required 0", s_ready); end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid: got %b required 0", m_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b required 0", done); end
      tests++; if (m_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_m_data: got %h required 00000000", m_data); end
      #2 rst = 1'b0;
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_busy: got %b required 0", busy); end
   endtask

   task automatic test_basic();
      int d0;
      start_tile(16'd2);
      tests++; if (s_ready !== 1'b1) begin fails++; $display("[TB] FAIL basic_s_ready_after_start: got %b required 1", s_ready); end
      tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy_after_start: got %b required 1", busy); end
      for (int k = 0; k < 4; k++) send_byte(8'h11 + 8'(k));
      tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_w0_valid: got %b required 1", m_valid); end
      tests++; if (m_data !== 32'h14131211) begin fails++; $display("[TB] FAIL basic_w0_data: got %h required 14131211", m_data); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      tests++; if (s_ready !== 1'b1) begin fails++; $display("[TB] FAIL basic_refill_s_ready: got %b required 1", s_ready); end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_refill_m_valid: got %b required 0", m_valid); end
      for (int k = 0; k < 4; k++) send_byte(8'h15 + 8'(k));
      tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_w1_valid: got %b required 1", m_valid); end
      tests++; if (m_data !== 32'h18171615) begin fails++; $display("[TB] FAIL basic_w1_data: got %h required 18171615", m_data); end
      d0 = done_seen;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL basic_done: got %b required 1", done); end
      tick();
      tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_one_cycle: got %b required 0", done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_end: got %b required 0", busy); end
      tests++; if (done_seen !== d0 + 1) begin fails++; $display("[TB] FAIL basic_done_count: got %0d required %0d", done_seen - d0, 1); end
   endtask

   task automatic test_hold_stall();
      start_tile(16'd1);
      for (int k = 0; k < 4; k++) send_byte(8'h21 + 8'(k));
      s_valid = 1'b1;
      s_data  = 8'h99;
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_m_valid[%0d]: got %b required 1", i, m_valid); end
         tests++; if (m_data !== 32'h24232221) begin fails++; $display("[TB] FAIL stall_m_data[%0d]: got %h required 24232221", i, m_data); end
         tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_s_ready[%0d]: got %b required 0", i, s_ready); end
         tick();
      end
      m_ready = 1'b1;
      s_valid = 1'b0;
      tick();
      m_ready = 1'b0;
      tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL stall_done: got %b required 1", done); end
      tick();
   endtask

   task automatic test_sparse_valid();
      start_tile(16'd1);
      for (int k = 0; k < 4; k++) begin
         s_valid = 1'b0;
         tick();
         s_data  = 8'h31 + 8'(k);
         s_valid = 1'b1;
         tick();
         s_valid = 1'b0;
         if (k < 3) begin
            tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL sparse_early_valid[%0d]: got %b required 0", k, m_valid); end
         end
      end
      tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL sparse_valid: got %b required 1", m_valid); end
      tests++; if (m_data !== 32'h34333231) begin fails++; $display("[TB] FAIL sparse_data: got %h required 34333231", m_data); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL sparse_done: got %b required 1", done); end
      tick();
   endtask

   task automatic test_zero_len();
      int d0;
      d0        = done_seen;
      cfg_words = '0;
      start     = 1'b1;
      s_valid   = 1'b1;
      s_data    = 8'h77;
      tick();
      start     = 1'b0;
      tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL zero_done: got %b required 1", done); end
      tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL zero_s_ready_done: got %b required 0", s_ready); end
      tick();
      tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL zero_done_clear: got %b required 0", done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL zero_busy: got %b required 0", busy); end
      tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL zero_s_ready_idle: got %b required 0", s_ready); end
      tests++; if (done_seen !== d0 + 1) begin fails++; $display("[TB] FAIL zero_done_count: got %0d required 1", done_seen - d0); end
      s_valid = 1'b0;
   endtask

   task automatic test_abort();
      int d0;
      d0 = done_seen;
      start_tile(16'd4);
      send_byte(8'hE0);
      send_byte(8'hE1);
      abort   = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hEE;
      #1;
      tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL abort_s_ready: got %b required 0", s_ready); end
      tick();
      abort   = 1'b0;
      s_valid = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b required 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL abort_done: got %b required 0", done); end
      start_tile(16'd1);
      for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k));
      tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL abort_new_valid: got %b required 1", m_valid); end
      tests++; if (m_data !== 32'hA3A2A1A0) begin fails++; $display("[TB] FAIL abort_new_data: got %h required A3A2A1A0", m_data); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL abort_new_done: got %b required 1", done); end
      tick();
      tests++; if (done_seen !== d0 + 1) begin fails++; $display("[TB] FAIL abort_done_count: got %0d required 1", done_seen - d0); end
   endtask

   task automatic test_back_to_back();
      int          cyc;
      int          nw;
      logic        acc;
      logic [31:0] w [2];
      w[0]      = '0;
      w[1]      = '0;
      nw        = 0;
      cfg_words = 16'd2;
      start     = 1'b1;
      s_valid   = 1'b1;
      s_data    = 8'hC0;
      m_ready   = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 30) begin
         acc = s_valid && s_ready;
         if (m_valid && nw < 2) begin
            w[nw] = m_data;
            nw++;
         end
         tick();
         cyc++;
         if (acc) s_data = s_data + 8'd1;
      end
      s_valid = 1'b0;
      m_ready = 1'b0;
      tests++; if (cyc != 11) begin fails++; $display("[TB] FAIL b2b_done_cycle: got %0d required 11", cyc); end
      tests++; if (nw != 2) begin fails++; $display("[TB] FAIL b2b_word_count: got %0d required 2", nw); end
      tests++; if (w[0] !== 32'hC3C2C1C0) begin fails++; $display("[TB] FAIL b2b_w0: got %h required C3C2C1C0", w[0]); end
      tests++; if (w[1] !== 32'hC7C6C5C4) begin fails++; $display("[TB] FAIL b2b_w1: got %h required C7C6C5C4", w[1]); end
      tick();
   endtask

   task automatic test_reset_mid_hold();
      start_tile(16'd2);
      for (int k = 0; k < 4; k++) send_byte(8'h51 + 8'(k));
      tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL rsthold_pre_valid: got %b required 1", m_valid); end
      #2 rst = 1'b1;
      #1;
      tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL rsthold_m_valid: got %b required 0", m_valid); end
      tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL rsthold_s_ready: got %b required 0", s_ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rsthold_busy: got %b required 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL rsthold_done: got %b required 0", done); end
      tests++; if (m_data !== 32'h0) begin fails++; $display("[TB] FAIL rsthold_m_data: got %h required 00000000", m_data); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      start_tile(16'd1);
      tests++; if (s_ready !== 1'b1) begin fails++; $display("[TB] FAIL rsthold_restart_s_ready: got %b required 1", s_ready); end
      for (int k = 0; k < 4; k++) send_byte(8'h61 + 8'(k));
      tests++; if (m_data !== 32'h64636261) begin fails++; $display("[TB] FAIL rsthold_restart_data: got %h required 64636261", m_data); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL rsthold_restart_done: got %b required 1", done); end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold_stall();
      test_sparse_valid();
      test_zero_len();
      test_abort();
      test_back_to_back();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifmap_load_ctrl.md
# ifmap_load_ctrl

Controller that sequences the input-feature-map byte packer for one tile. It accepts a byte stream over a valid/ready handshake and drives the packer's shift enable. Each completed (BUS+1)-bit word is presented to the PE-array side over a second valid/ready handshake. It counts words per tile and pulses `done` when the programmed tile length has been delivered.

## Interface
Parameters:
- `BUS`, default 31: word MSB index; word width is BUS+1. (BUS+1) must be a multiple of 8 and ≥ 16.
- `CNT_W`, default 16: width of the tile word counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  tile start pulse; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE from any state.
- `cfg_words`  in  CNT_W  words in the tile; sampled on accepted `start`.
- `s_data`  in  8  input byte.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  controller accepts a byte this cycle.
- `m_data`  out  BUS+1  packed word.
- `m_valid`  out  1  packed word valid.
- `m_ready`  in  1  downstream accepts the word.
- `busy`  out  1  high in FILL, HOLD and DONE.
- `done`  out  1  one-cycle pulse at tile completion.

## Operation
- Definitions:
  - BYTES = (BUS+1)/8.
  - `byte_cnt` is 0..BYTES-1.
  - `words_left` is CNT_W bits wide.
- Byte order: byte k (0-based, in arrival order) of a word lands in `m_data[8k+7:8k]`. Each accepted byte shifts in at the MSB lane and right-shifts the buffer by 8.
- States: IDLE, FILL, HOLD, DONE. All outputs are registered or decoded from state.
- IDLE:
  - Outputs: `s_ready`=0, `m_valid`=0.
  - `start`=1 with `cfg_words`≠0 → FILL; `words_left`←cfg_words, `byte_cnt`←0.
  - `start`=1 with `cfg_words`=0 → DONE. No bytes are accepted.
- FILL:
  - `s_ready`=1.
  - On `s_valid`&`s_ready`: packer enable=1 for that cycle and `byte_cnt`++.
  - Accept with `byte_cnt`=BYTES-1 → HOLD, `byte_cnt`←0.
  - Cycles with `s_valid`=0 leave the packer and counters unchanged.
- HOLD:
  - `m_valid`=1, `s_ready`=0, `m_data` stable. Packer enable=0, so no overlap of fill and drain.
  - On `m_ready`: `words_left`--. If `words_left` was 1 → DONE, else → FILL.
  - `m_valid` stays high until `m_ready`; the word is never dropped or changed.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored.
- `abort`:
  - Takes priority over every other transition: next state IDLE and counters cleared.
  - No `done` pulse. Any partial word is discarded.
  - A byte presented in the abort cycle is not accepted (`s_ready` is forced to 0 combinationally when `abort`=1).
- `abort` together with `start` in IDLE: abort wins, and the controller stays in IDLE.
- `m_data` is meaningful only while `m_valid`=1.

## Timing
- Reset values:
  - `s_ready`=0, `m_valid`=0, `busy`=0, `done`=0, `m_data`=0.
  - State IDLE, counters 0.
- `start` accepted at edge N → `s_ready`=1 and `busy`=1 from cycle N+1.
- Last byte of a word accepted at edge N → `m_valid`=1 in cycle N+1.
- `m_ready` at edge M:
  - Not the last word → `s_ready`=1 in cycle M+1.
  - Last word → `done`=1 in cycle M+1 and `busy`=0 in cycle M+2.
- Maximum throughput: one word per BYTES+1 cycles, with `s_valid` and `m_ready` held high.
- Zero-length tile: `start` at edge N → `done`=1 in cycle N+1.
- Reset mid-tile clears everything immediately; the packer buffer is also cleared.

## Structure
- Package `ifmap_pkg`:
  - State encoding type (IDLE, FILL, HOLD, DONE).
  - Function returning BYTES for a given BUS.
- Sub-module `byte_packer`: BUS+1-bit shift buffer with enable and async reset. It is instantiated once; its output drives `m_data` directly.
- All FSM, counter and handshake logic lives in the top module.

## Test plan
- BUS=31, `cfg_words`=2, bytes 0x11..0x18 streamed with `m_ready`=1 → `m_data`=0x14131211 then 0x18171615. `done` pulses once, 1 cycle after the 2nd `m_ready`.
- `m_ready` held low for 5 cycles in HOLD, with `s_valid` held high → `m_valid` stays 1, `m_data` is stable and `s_ready`=0 throughout.
- `s_valid` toggled every other cycle → word is assembled correctly, and each byte is accepted exactly once.
- `cfg_words`=0 → `done` in the cycle after `start`, and `s_ready` is never asserted.
- `abort` after 2 of 4 bytes, then a new `start` with `cfg_words`=1 and bytes 0xA0..0xA3 → `m_data`=0xA3A2A1A0, with no stale bytes and no `done` for the aborted tile.
- Async `rst` asserted mid-HOLD → all outputs are 0 immediately. After release, `start` behaves as from power-up.
